// File: rtl/proc_pkg.sv
// Shared definitions for the 9-bit processor instruction sequencer.
// Contents: opcode encodings, the immediate-class helper, and the sequencer state encoding.
package proc_pkg;

  // Opcode field is MemData[8:6].
  localparam logic [2:0] MV     = 3'b000;
  localparam logic [2:0] MVI    = 3'b001;
  localparam logic [2:0] ADD    = 3'b010;
  localparam logic [2:0] SUB    = 3'b011;
  localparam logic [2:0] ADDI   = 3'b100;
  localparam logic [2:0] MVIALL = 3'b101;
  localparam logic [2:0] ILL    = 3'b110;
  localparam logic [2:0] HALT   = 3'b111;

  // Instructions followed by an immediate word in the program.
  function automatic logic is_imm(input logic [2:0] op);
    return (op == MVI) || (op == ADDI) || (op == MVIALL);
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    EXEC,
    HALTED,
    ERROR
  } state_e;

endpackage

// File: rtl/proc_seq.sv
// Instruction sequencer: fetches program words from an external synchronous ROM, drives the
// processor's DIN/Run, waits for Done, and skips immediate words of MVI/ADDI/MVIALL.
// Ports:
//   Clock, Reset       - clock and synchronous active-high reset
//   Start              - begin at address 0 (only from IDLE/HALTED/ERROR)
//   MemAddr / MemData  - registered ROM address / ROM read word
//   DIN, Run, Done     - processor data input, issue strobe, completion
//   ProcResetn         - registered active-low processor reset
//   Busy, Halted, Error, PC, InstrCount - status
module proc_seq
  import proc_pkg::*;
#(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned WD_LIMIT = 3
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic [8:0]        MemData,
  output logic [8:0]        DIN,
  output logic              Run,
  input  logic              Done,
  output logic              ProcResetn,
  output logic              Busy,
  output logic              Halted,
  output logic              Error,
  output logic [ADDR_W-1:0] PC,
  output logic [7:0]        InstrCount
);

  localparam int unsigned CntW = $clog2(WD_LIMIT + 1);
  localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [2:0]        op_q, op_d;
  logic [CntW-1:0]   exec_cnt_q, exec_cnt_d;
  logic [7:0]        instr_cnt_q, instr_cnt_d;
  logic              proc_resetn_q, proc_resetn_d;
  logic              run;
  logic [2:0]        opcode;
  logic [ADDR_W-1:0] pc_next;

  assign opcode = MemData[8:6];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mem_addr_d  = mem_addr_q;
    op_d        = op_q;
    exec_cnt_d  = exec_cnt_q;
    instr_cnt_d = instr_cnt_q;
    run         = 1'b0;
    pc_next     = pc_q;

    unique case (state_q)
      IDLE, HALTED, ERROR: begin
        if (Start) begin
          state_d     = FETCH;
          pc_d        = '0;
          mem_addr_d  = '0;
          instr_cnt_d = '0;
        end
      end
      // ROM latency cycle: MemAddr already points at PC.
      FETCH: state_d = ISSUE;
      ISSUE: begin
        if (opcode == HALT) begin
          state_d = HALTED;
        end else if (opcode == ILL) begin
          state_d = ERROR;
        end else begin
          // Processor sits in T0 and captures IR from DIN at this edge.
          run        = 1'b1;
          op_d       = opcode;
          pc_d       = pc_q + AddrOne;
          mem_addr_d = pc_q + AddrOne;
          exec_cnt_d = CntW'(1);
          state_d    = EXEC;
        end
      end
      EXEC: begin
        // MemAddr stays at the immediate word so DIN is stable for every EXEC cycle.
        if (Done) begin
          pc_next     = is_imm(op_q) ? pc_q + AddrOne : pc_q;
          pc_d        = pc_next;
          mem_addr_d  = pc_next;
          instr_cnt_d = (instr_cnt_q == 8'hff) ? instr_cnt_q : instr_cnt_q + 8'd1;
          state_d     = FETCH;
        end else if (exec_cnt_q == CntW'(WD_LIMIT)) begin
          state_d = ERROR;
        end else begin
          exec_cnt_d = exec_cnt_q + CntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Keep the processor in reset for as long as the sequencer sits in ERROR.
    proc_resetn_d = (state_d != ERROR);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      mem_addr_q    <= '0;
      op_q          <= MV;
      exec_cnt_q    <= '0;
      instr_cnt_q   <= '0;
      proc_resetn_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      mem_addr_q    <= mem_addr_d;
      op_q          <= op_d;
      exec_cnt_q    <= exec_cnt_d;
      instr_cnt_q   <= instr_cnt_d;
      proc_resetn_q <= proc_resetn_d;
    end
  end

  assign MemAddr    = mem_addr_q;
  assign DIN        = MemData;
  assign Run        = run;
  assign ProcResetn = proc_resetn_q;
  assign Busy       = (state_q == FETCH) || (state_q == ISSUE) || (state_q == EXEC);
  assign Halted     = (state_q == HALTED);
  assign Error      = (state_q == ERROR);
  assign PC         = pc_q;
  assign InstrCount = instr_cnt_q;

endmodule

// File: tb/tb_proc_seq.sv
// Testbench for proc_seq: a behavioural ROM and processor model around the sequencer,
// a table of single-instruction programs, and hand-written multi-cycle sequences.
module tb_proc_seq;

  logic       Clock, Reset, Start;
  logic [4:0] MemAddr, PC;
  logic [8:0] MemData, DIN;
  logic       Run, Done, ProcResetn, Busy, Halted, Error;
  logic [7:0] InstrCount;

  logic       Start2;
  logic [1:0] MemAddr2, PC2;
  logic [8:0] MemData2, DIN2;
  logic       Run2, Done2, ProcResetn2, Busy2, Halted2, Error2;
  logic [7:0] InstrCount2;

  logic [8:0] rom  [32];
  logic [8:0] rom2 [4];

  assign MemData  = rom[MemAddr];
  assign MemData2 = rom2[MemAddr2];

  proc_seq #(.ADDR_W(5), .WD_LIMIT(3)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .MemAddr(MemAddr), .MemData(MemData),
    .DIN(DIN), .Run(Run), .Done(Done), .ProcResetn(ProcResetn), .Busy(Busy),
    .Halted(Halted), .Error(Error), .PC(PC), .InstrCount(InstrCount)
  );

  proc_seq #(.ADDR_W(2), .WD_LIMIT(3)) dut2 (
    .Clock(Clock), .Reset(Reset), .Start(Start2), .MemAddr(MemAddr2), .MemData(MemData2),
    .DIN(DIN2), .Run(Run2), .Done(Done2), .ProcResetn(ProcResetn2), .Busy(Busy2),
    .Halted(Halted2), .Error(Error2), .PC(PC2), .InstrCount(InstrCount2)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Processor model: T0 waits for Run, Done at T1 (MV/MVI/MVIALL) or T3 (ADD/SUB/ADDI).
  logic [1:0] t_q   = '0;
  logic [8:0] ir_q  = '0;
  logic [8:0] opnd_q = '0;
  logic [8:0] r [8];
  logic       done_en = 1'b1;
  logic       pdone;
  int         run_cnt = 0;

  always_comb begin
    pdone = 1'b0;
    case (ir_q[8:6])
      3'b000, 3'b001, 3'b101: pdone = (t_q == 2'd1);
      3'b010, 3'b011, 3'b100: pdone = (t_q == 2'd3);
      default:                pdone = 1'b0;
    endcase
  end
  assign Done = done_en && pdone;

  always @(posedge Clock) begin
    if (Reset) begin
      r[0] <= 9'd5; r[1] <= 9'd3; r[2] <= 9'd10; r[3] <= 9'd0;
      r[4] <= 9'd0; r[5] <= 9'd0; r[6] <= 9'd0; r[7] <= 9'd0;
      run_cnt <= 0;
    end else if (Run) begin
      run_cnt <= run_cnt + 1;
    end
    if (!ProcResetn) begin
      t_q <= 2'd0;
    end else if (t_q == 2'd0) begin
      if (Run) begin
        ir_q <= DIN;
        t_q  <= 2'd1;
      end
    end else if (Done) begin
      t_q <= 2'd0;
      case (ir_q[8:6])
        3'b000: r[ir_q[5:3]] <= r[ir_q[2:0]];
        3'b001: r[ir_q[5:3]] <= DIN;
        3'b010: r[ir_q[5:3]] <= r[ir_q[5:3]] + r[ir_q[2:0]];
        3'b011: r[ir_q[5:3]] <= r[ir_q[5:3]] - r[ir_q[2:0]];
        3'b100: r[ir_q[5:3]] <= r[ir_q[5:3]] + opnd_q;
        3'b101: for (int i = 0; i < 8; i++) r[i] <= DIN;
        default: ;
      endcase
    end else begin
      if (t_q == 2'd2) opnd_q <= DIN;
      t_q <= t_q + 2'd1;
    end
  end

  // Second processor stand-in: Done one cycle after Run (single-cycle EXEC).
  logic run2_q = 1'b0;
  always @(posedge Clock) run2_q <= ProcResetn2 ? Run2 : 1'b0;
  assign Done2 = run2_q;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset  = 1'b1;
    Start  = 1'b0;
    Start2 = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic fill_rom(input logic [8:0] w);
    for (int i = 0; i < 32; i++) rom[i] = w;
  endtask

  // Pulse Start, then count cycles until Halted or Error (bounded).
  task automatic run_prog(output int n, output int first_run);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    n = 0;
    first_run = -1;
    while (!(Halted || Error) && n < 60) begin
      if (Run && first_run < 0) first_run = n;
      tick();
      n++;
    end
  endtask

  typedef struct {
    logic [8:0] w0;
    logic [8:0] w1;
    int         reg_i;
    int         exp_val;
    int         exp_pc;
    int         exp_cnt;
    int         exp_cyc;
    bit         exp_halt;
    int         exp_runs;
  } vec_t;

  vec_t vecs [8];
  int   n, fr, k;

  initial begin
    // Presets: R0=5, R1=3, R2=10, others 0.
    vecs[0] = '{9'h048, 9'h003, 1, 3,   2, 1, 5, 1'b1, 1};  // MVI R1,#3
    vecs[1] = '{9'h002, 9'h1C0, 0, 10,  1, 1, 5, 1'b1, 1};  // MV R0,R2
    vecs[2] = '{9'h081, 9'h1C0, 0, 8,   1, 1, 7, 1'b1, 1};  // ADD R0,R1
    vecs[3] = '{9'h0D0, 9'h1C0, 2, 5,   1, 1, 7, 1'b1, 1};  // SUB R2,R0
    vecs[4] = '{9'h100, 9'h007, 0, 12,  2, 1, 7, 1'b1, 1};  // ADDI R0,#7
    vecs[5] = '{9'h140, 9'h1AB, 5, 427, 2, 1, 5, 1'b1, 1};  // MVIALL #0x1AB
    vecs[6] = '{9'h180, 9'h000, 0, 5,   0, 0, 2, 1'b0, 0};  // illegal
    vecs[7] = '{9'h1C0, 9'h000, 0, 5,   0, 0, 2, 1'b1, 0};  // HALT

    fill_rom(9'h1C0);
    for (int i = 0; i < 4; i++) rom2[i] = 9'h1C0;

    // Reset values.
    do_reset();
    check("rst_busy", int'(Busy), 0);
    check("rst_halted", int'(Halted), 0);
    check("rst_error", int'(Error), 0);
    check("rst_run", int'(Run), 0);
    check("rst_pc", int'(PC), 0);
    check("rst_memaddr", int'(MemAddr), 0);
    check("rst_icount", int'(InstrCount), 0);
    check("rst_procresetn", int'(ProcResetn), 0);
    tick();
    check("rst_procresetn_release", int'(ProcResetn), 1);

    // Table of single-instruction programs followed by HALT.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      fill_rom(9'h1C0);
      rom[0] = vecs[i].w0;
      rom[1] = vecs[i].w1;
      tick();
      run_prog(n, fr);
      check($sformatf("v%0d_cycles", i), n, vecs[i].exp_cyc);
      check($sformatf("v%0d_halted", i), int'(Halted), int'(vecs[i].exp_halt));
      check($sformatf("v%0d_error", i), int'(Error), int'(!vecs[i].exp_halt));
      check($sformatf("v%0d_pc", i), int'(PC), vecs[i].exp_pc);
      check($sformatf("v%0d_icount", i), int'(InstrCount), vecs[i].exp_cnt);
      check($sformatf("v%0d_reg", i), int'(r[vecs[i].reg_i]), vecs[i].exp_val);
      check($sformatf("v%0d_runs", i), run_cnt, vecs[i].exp_runs);
      check($sformatf("v%0d_procresetn", i), int'(ProcResetn), int'(vecs[i].exp_halt));
      if (vecs[i].exp_runs > 0) check($sformatf("v%0d_run_at", i), fr, 1);
    end

    // MVI R1,#3 ; ADD R1,R1 ; HALT
    do_reset();
    fill_rom(9'h1C0);
    rom[0] = 9'h048;
    rom[1] = 9'h003;
    rom[2] = 9'h089;
    tick();
    run_prog(n, fr);
    check("seq2_cycles", n, 10);
    check("seq2_r1", int'(r[1]), 6);
    check("seq2_icount", int'(InstrCount), 2);
    check("seq2_halted", int'(Halted), 1);
    check("seq2_runs", run_cnt, 2);
    check("seq2_pc", int'(PC), 3);

    // Watchdog: Done never arrives after MV R0,R1.
    do_reset();
    fill_rom(9'h1C0);
    rom[0] = 9'h001;
    done_en = 1'b0;
    tick();
    run_prog(n, fr);
    check("wd_cycles", n, 5);
    check("wd_error", int'(Error), 1);
    check("wd_pc", int'(PC), 1);
    check("wd_procresetn", int'(ProcResetn), 0);
    check("wd_runs", run_cnt, 1);
    check("wd_r0", int'(r[0]), 5);
    done_en = 1'b1;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("wd_recover_busy", int'(Busy), 1);
    check("wd_recover_error", int'(Error), 0);
    check("wd_recover_pc", int'(PC), 0);
    check("wd_recover_procresetn", int'(ProcResetn), 1);

    // Illegal opcode, then Start recovers to FETCH.
    do_reset();
    fill_rom(9'h1C0);
    rom[0] = 9'h180;
    tick();
    run_prog(n, fr);
    check("ill_error", int'(Error), 1);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("ill_recover_busy", int'(Busy), 1);
    check("ill_recover_pc", int'(PC), 0);

    // Reset during EXEC cycle 2 of an ADD.
    do_reset();
    fill_rom(9'h1C0);
    rom[0] = 9'h081;
    tick();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    tick();
    tick();
    check("midrst_busy_before", int'(Busy), 1);
    check("midrst_pc_before", int'(PC), 1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("midrst_busy", int'(Busy), 0);
    check("midrst_pc", int'(PC), 0);
    check("midrst_memaddr", int'(MemAddr), 0);
    check("midrst_run", int'(Run), 0);
    check("midrst_flags", int'({Halted, Error}), 0);
    check("midrst_icount", int'(InstrCount), 0);
    check("midrst_procresetn", int'(ProcResetn), 0);
    tick();
    check("midrst_procresetn_release", int'(ProcResetn), 1);
    check("midrst_idle", int'(Busy), 0);

    // Endless MV loop: Start while busy is ignored, InstrCount saturates.
    do_reset();
    fill_rom(9'h000);
    tick();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    k = 0;
    while (PC != 5'd10 && k < 100) begin
      tick();
      k++;
    end
    check("loop_reach_pc10", int'(PC), 10);
    Start = 1'b1;
    tick();
    tick();
    tick();
    Start = 1'b0;
    check("busy_start_pc", int'(PC), 11);
    check("busy_start_busy", int'(Busy), 1);
    repeat (800) tick();
    check("sat_icount", int'(InstrCount), 255);
    check("sat_busy", int'(Busy), 1);

    // ADDR_W=2: MVI at address 3 takes its immediate from address 0.
    do_reset();
    rom2[0] = 9'h005;
    rom2[1] = 9'h040;
    rom2[2] = 9'h000;
    rom2[3] = 9'h040;
    tick();
    Start2 = 1'b1;
    tick();
    Start2 = 1'b0;
    k = 0;
    while (!(Run2 && MemAddr2 == 2'd3) && k < 40) begin
      tick();
      k++;
    end
    check("wrap_reach_issue", int'(Run2 && MemAddr2 == 2'd3), 1);
    tick();
    check("wrap_imm_addr", int'(MemAddr2), 0);
    check("wrap_imm_din", int'(DIN2), 5);
    check("wrap_pc", int'(PC2), 0);
    tick();
    check("wrap_next_addr", int'(MemAddr2), 1);
    check("wrap_next_pc", int'(PC2), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

endmodule

// File: doc/proc_seq.md
# proc_seq

Instruction sequencer for the multi-cycle 9-bit processor. It fetches words from a synchronous program ROM and drives the processor's DIN and Run. It waits for Done, and steps the program counter past immediate words for MVI, ADDI and MVIALL. It sits between the program ROM and the processor inside the top level, and replaces manual DIN/Run driving from switches.

## Interface
Parameters:
- ADDR_W, 5, ROM address width; PC wraps at 2^ADDR_W.
- WD_LIMIT, 3, maximum EXEC cycles allowed before Done must appear.

Ports:
- Clock  in  1  system clock, all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  begin execution at address 0; honoured only in IDLE, HALTED or ERROR.
- MemAddr  out  ADDR_W  ROM read address, registered.
- MemData  in  9  ROM read data, valid one cycle after MemAddr.
- DIN  out  9  processor data input; combinational copy of MemData.
- Run  out  1  processor Run; high for exactly one cycle per issued instruction.
- Done  in  1  processor Done, combinational from the processor FSM.
- ProcResetn  out  1  active-low processor reset, registered.
- Busy  out  1  high in FETCH, ISSUE and EXEC.
- Halted  out  1  high in HALTED.
- Error  out  1  high in ERROR.
- PC  out  ADDR_W  current program counter.
- InstrCount  out  8  count of completed instructions, saturating at 255.

## Operation
- Opcode is MemData[8:6]. The following encodings apply:
  - 000 MV, 001 MVI, 010 ADD, 011 SUB, 100 ADDI and 101 MVIALL are issued to the processor.
  - 111 is HALT and is never issued.
  - 110 is illegal and is never issued.
- IMM class: MVI, ADDI, MVIALL. Each occupies two words: the instruction, then the immediate.
- FSM states and transitions:
  - IDLE: MemAddr=PC. Start -> FETCH with PC=0 and InstrCount=0.
  - FETCH: MemAddr=PC; ROM latency cycle. Always -> ISSUE.
  - ISSUE: MemData holds the instruction.
    - Opcode 111 -> HALTED, Run=0.
    - Opcode 110 -> ERROR, Run=0.
    - Otherwise: Run=1 (processor is in T0 and captures IR at this edge), latch the opcode, MemAddr<=PC+1, PC<=PC+1, -> EXEC.
  - EXEC: Run=0. DIN=MemData is the word at the old PC+1, which is the immediate; it is held stable for the whole state. Count EXEC cycles from 1.
    - On Done: PC<=PC+1 if the opcode is in the IMM class, MemAddr<=the new PC, InstrCount++, -> FETCH.
    - If the count reaches WD_LIMIT without Done -> ERROR.
  - HALTED / ERROR: hold PC. Start -> FETCH with PC=0 and InstrCount=0, flags cleared.
- ProcResetn is 0 during Reset, for the first cycle after Reset deasserts, and for every cycle in ERROR. It is 1 otherwise.
- PC and MemAddr arithmetic is modulo 2^ADDR_W. An immediate at the last address wraps to address 0.
- Start while Busy is ignored.
- Done seen outside EXEC is ignored.

## Timing
- Reset values: IDLE, PC=0, MemAddr=0, Run=0, Busy=0, Halted=0, Error=0, InstrCount=0, ProcResetn=0.
- Run is asserted in ISSUE, the second cycle after entering FETCH.
- Expected Done timing:
  - MV, MVI, MVIALL: Done in EXEC cycle 1 (processor T1). Each instruction takes 3 cycles.
  - ADD, SUB, ADDI: Done in EXEC cycle 3 (processor T3). Each instruction takes 5 cycles.
- ADDI consumes its immediate in EXEC cycle 2. MVI and MVIALL consume it in EXEC cycle 1. MemData must be stable across all EXEC cycles.
- Reset mid-EXEC: the sequencer returns to IDLE in one cycle. ProcResetn low returns the processor to T0, so no instruction is left half-issued.
- Start and Done in the same cycle cannot occur in a legal sequence. Start has no effect while in EXEC.

## Structure
- proc_pkg holds:
  - opcode localparams MV, MVI, ADD, SUB, ADDI, MVIALL, ILL=3'b110, HALT=3'b111;
  - the is_imm function;
  - the state encoding IDLE, FETCH, ISSUE, EXEC, HALTED, ERROR.
- No sub-module. There is a single FSM with PC, EXEC-count and InstrCount registers, and the ROM stays external.

## Test plan
- ROM {0: 001_000_000, 1: 000000101, 2: 111_000_000}, Start -> Run at cycle 2, Done in EXEC 1. Then PC=2, HALTED. Processor R0=5, InstrCount=1.
- ROM {0: MVI R1 #3, 2: ADD R1,R1 (010_001_001), 3: HALT} -> ADD takes 5 cycles with Run high once, R1=6, InstrCount=2, Halted=1.
- ADDI R0 #7 with R0=5 -> DIN=7 in EXEC cycle 2, R0=12, PC advances by 2.
- Opcode 110 at address 0 -> Run never asserted, Error=1, ProcResetn=0. Start then recovers to FETCH with PC=0.
- Done held low by the bench after Run -> Error after 3 EXEC cycles, PC unchanged.
- With ADDR_W=2, MVI at address 3 -> immediate read from address 0, next fetch at address 1. Separately, Reset asserted in EXEC cycle 2 -> IDLE, ProcResetn=0, all outputs at their reset values.
